// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b pipeline types.
//   stage_occ_t  occupancy state of a pipeline stage buffer (EMPTY, ONE, TWO).
//   STALL_W      width of stall counters.
//   STALL_MAX    saturation value of stall counters.
package lc3b_types;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_occ_t;

    localparam int unsigned         STALL_W   = 16;
    localparam logic [STALL_W-1:0] STALL_MAX = '1;

endpackage

// File: rtl/stage_buffer_reg.sv
// stage_buffer_reg: parametrised load-enabled register with synchronous active-high reset.
// Ports:
//   i_clk    clock, rising edge
//   i_reset  synchronous reset, clears the register to zero (dominates i_load)
//   i_load   capture i_d on the next rising edge
//   i_d      data in  [WIDTH-1:0]
//   o_q      data out [WIDTH-1:0]
module stage_buffer_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/stage_buffer.sv
// stage_buffer: valid/ready pipeline stage buffer carrying NUM_WORDS words and NUM_REGS
// register indices per entry, with flush and a saturating stall counter.
// Build option: define STAGE_BUFFER_SKID_EN for a two-entry skid buffer whose in_ready
// depends only on registered state; otherwise a single entry with in_ready passing
// out_ready through combinationally.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   flush                 drop every held entry and any entry offered this cycle
//   in_valid/in_ready     upstream handshake; in_words/in_regs payload (field 0 in LSBs)
//   out_valid/out_ready   downstream handshake; out_words/out_regs head payload
//   stall_count           saturating count of cycles with out_valid && !out_ready
module stage_buffer
    import lc3b_types::*;
#(
    parameter int unsigned WORD_W    = 16,
    parameter int unsigned NUM_WORDS = 7,
    parameter int unsigned REG_W     = 3,
    parameter int unsigned NUM_REGS  = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_WORDS*WORD_W-1:0]   in_words,
    input  logic [NUM_REGS*REG_W-1:0]     in_regs,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_WORDS*WORD_W-1:0]   out_words,
    output logic [NUM_REGS*REG_W-1:0]     out_regs,
    output logic [15:0]                   stall_count
);

    localparam int unsigned WORDS_W = NUM_WORDS * WORD_W;
    localparam int unsigned REGS_W  = NUM_REGS * REG_W;
    localparam int unsigned PAY_W   = WORDS_W + REGS_W;

    stage_occ_t       r_state;
    stage_occ_t       w_state_nxt;
    logic [PAY_W-1:0] w_in_pay;
    logic [PAY_W-1:0] w_head_d;
    logic [PAY_W-1:0] w_head_q;
    logic             w_head_load;
    logic             w_acc;
    logic             w_rel;
    logic [15:0]      r_stall;

    // Payload packs regs above words so the head splits back cleanly.
    assign w_in_pay  = {in_regs, in_words};
    assign out_valid = (r_state != EMPTY);

`ifdef STAGE_BUFFER_SKID_EN
    logic [PAY_W-1:0] w_skid_q;
    logic             w_skid_load;

    // Registered ready: the skid slot absorbs the entry accepted while out_ready drops.
    assign in_ready = (r_state != TWO);
`else
    assign in_ready = !out_valid || out_ready;
`endif

    assign w_acc = in_valid && in_ready;
    assign w_rel = out_valid && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_head_load = 1'b0;
        w_head_d    = w_in_pay;
`ifdef STAGE_BUFFER_SKID_EN
        w_skid_load = 1'b0;
`endif
        if (flush) begin
            // Flush leaves the head payload untouched; only occupancy is cleared.
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_acc) begin
                        w_head_load = 1'b1;
                        w_state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (w_acc && w_rel) begin
                        w_head_load = 1'b1;
`ifdef STAGE_BUFFER_SKID_EN
                    end else if (w_acc) begin
                        w_skid_load = 1'b1;
                        w_state_nxt = TWO;
`endif
                    end else if (w_rel) begin
                        w_state_nxt = EMPTY;
                    end
                end
`ifdef STAGE_BUFFER_SKID_EN
                TWO: begin
                    if (w_rel) begin
                        w_head_d    = w_skid_q;
                        w_head_load = 1'b1;
                        w_state_nxt = ONE;
                    end
                end
`endif
                default: begin
                    w_state_nxt = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    stage_buffer_reg #(
        .WIDTH (PAY_W)
    ) u_head (
        .i_clk   (clk),
        .i_reset (reset),
        .i_load  (w_head_load),
        .i_d     (w_head_d),
        .o_q     (w_head_q)
    );

`ifdef STAGE_BUFFER_SKID_EN
    stage_buffer_reg #(
        .WIDTH (PAY_W)
    ) u_skid (
        .i_clk   (clk),
        .i_reset (reset),
        .i_load  (w_skid_load),
        .i_d     (w_in_pay),
        .o_q     (w_skid_q)
    );
`endif

    assign out_words = w_head_q[WORDS_W-1:0];
    assign out_regs  = w_head_q[PAY_W-1:WORDS_W];

    // Counts stalls regardless of flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall <= '0;
        end else if (out_valid && !out_ready && (r_stall != STALL_MAX)) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign stall_count = r_stall;

endmodule

// File: tb/tb_stage_buffer.sv
// tb_stage_buffer: self-checking bench for stage_buffer (default parameters). A queue model
// predicts every output each cycle; directed sequences pin the model with literal values.
module tb_stage_buffer;

    localparam int WW = 16 * 7;
    localparam int RW = 3 * 3;
    localparam int PW = WW + RW;
`ifdef STAGE_BUFFER_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [WW-1:0] in_words = '0;
    logic [RW-1:0] in_regs = '0;
    logic          in_ready;
    logic          out_valid;
    logic [WW-1:0] out_words;
    logic [RW-1:0] out_regs;
    logic [15:0]   stall_count;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model: ordered contents, last shown payload, stall count.
    logic [PW-1:0] m_q[$];
    logic [PW-1:0] m_last = '0;
    int            m_stall = 0;

    stage_buffer u_dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_words    (in_words),
        .in_regs     (in_regs),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_words   (out_words),
        .out_regs    (out_regs),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [127:0] act,
                                input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Compare process: checks outputs against the model, then advances the model by the
    // upcoming rising edge using the inputs now held stable.
    always @(negedge clk) begin
        logic [PW-1:0] e_pay;
        bit            e_valid;
        bit            e_ready;
        e_valid = (m_q.size() > 0);
        e_pay   = e_valid ? m_q[0] : m_last;
        e_ready = SKID ? (m_q.size() < 2) : (!e_valid || out_ready);
        if (chk_en) begin
            chk("out_valid", 128'(out_valid), 128'(e_valid));
            chk("in_ready", 128'(in_ready), 128'(e_ready));
            chk("out_words", 128'(out_words), 128'(e_pay[WW-1:0]));
            chk("out_regs", 128'(out_regs), 128'(e_pay[PW-1:WW]));
            chk("stall_count", 128'(stall_count), 128'(m_stall));
        end
        if (reset) begin
            m_q.delete();
            m_last  = '0;
            m_stall = 0;
        end else begin
            if (e_valid && !out_ready && m_stall < 65535) m_stall++;
            if (flush) begin
                m_q.delete();
            end else begin
                if (e_valid && out_ready) void'(m_q.pop_front());
                if (in_valid && e_ready) m_q.push_back({in_regs, in_words});
            end
            if (m_q.size() > 0) m_last = m_q[0];
        end
    end

    initial begin
        logic [15:0] got[$];
        int          idx;
        bit          acc;
        bit          rel;
        int          rb;

        // Reset state.
        reset = 1'b1;
        cyc();
        chk_en = 1'b1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_words", 128'(out_words), 128'(0));
        chk("rst_out_regs", 128'(out_regs), 128'(0));
        chk("rst_stall", 128'(stall_count), 128'(0));

        // Latency 1 into an empty stage; payload held once empty again.
        reset = 1'b0;
        in_valid = 1'b1;
        in_words = '0;
        in_words[15:0] = 16'h1234;
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("lat1_valid", 128'(out_valid), 128'(1));
        chk("lat1_field0", 128'(out_words[15:0]), 128'(16'h1234));
        cyc();
        chk("drain_valid", 128'(out_valid), 128'(0));
        chk("hold_payload", 128'(out_words[15:0]), 128'(16'h1234));

        // Ordered stream with out_ready alternating.
        idx = 1;
        for (int k = 0; k < 60 && got.size() < 8; k++) begin
            out_ready = (k % 2 == 0);
            in_valid = (idx <= 8);
            in_words = '0;
            in_words[15:0] = 16'(idx);
            #1;
            acc = in_valid && in_ready;
            rel = out_valid && out_ready;
            if (rel) got.push_back(out_words[15:0]);
            cyc();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("stream_len", 128'(got.size()), 128'(8));
        for (int i = 0; i < 8; i++) begin
            chk("stream_order", 128'((i < got.size()) ? got[i] : 16'hxxxx), 128'(i + 1));
        end

        // Clear any remainder.
        flush = 1'b1;
        cyc();
        flush = 1'b0;

        // Back-pressure acceptance limit.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_words = '0;
        in_words[15:0] = 16'h00A1;
        cyc();
`ifdef STAGE_BUFFER_SKID_EN
        in_words[15:0] = 16'h00A2;
        cyc();
        in_words[15:0] = 16'h00A3;
        #1;
        chk("skid_full_ready", 128'(in_ready), 128'(0));
        cyc();
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("skid_rel0", 128'(out_words[15:0]), 128'(16'h00A1));
        cyc();
        chk("skid_rel1_valid", 128'(out_valid), 128'(1));
        chk("skid_rel1", 128'(out_words[15:0]), 128'(16'h00A2));
        cyc();
        chk("skid_empty", 128'(out_valid), 128'(0));
`else
        in_words[15:0] = 16'h00A2;
        #1;
        chk("one_full_ready", 128'(in_ready), 128'(0));
        cyc();
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("one_rel0", 128'(out_words[15:0]), 128'(16'h00A1));
        cyc();
        chk("one_empty", 128'(out_valid), 128'(0));
`endif

        // Flush with entries held and one offered.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_words[15:0] = 16'h00B1;
        cyc();
        in_words[15:0] = 16'h00B2;
        cyc();
        flush = 1'b1;
        out_ready = 1'b1;
        in_words[15:0] = 16'h00B3;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 128'(out_valid), 128'(0));
        chk("flush_ready", 128'(in_ready), 128'(1));
        repeat (3) cyc();
        chk("flush_gone", 128'(out_valid), 128'(0));

        // Reset and flush together while ONE.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_words[15:0] = 16'h00C1;
        in_regs = 9'h1A5;
        cyc();
        reset = 1'b1;
        flush = 1'b1;
        in_words[15:0] = 16'h00C2;
        cyc();
        reset = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("rf_valid", 128'(out_valid), 128'(0));
        chk("rf_ready", 128'(in_ready), 128'(1));
        chk("rf_words", 128'(out_words), 128'(0));
        chk("rf_regs", 128'(out_regs), 128'(0));
        chk("rf_stall", 128'(stall_count), 128'(0));
        out_ready = 1'b1;
        cyc();
        chk("rf_no_release", 128'(out_valid), 128'(0));

        // Randomized traffic with sparse reset and flush.
        for (int it = 0; it < 2000; it++) begin
            rb = (it / 250) % 4 + 1;
            reset = ($urandom_range(0, 99) < 2);
            flush = ($urandom_range(0, 15) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 4) < rb);
            for (int f = 0; f < 7; f++) in_words[f*16 +: 16] = 16'($urandom);
            in_regs = 9'($urandom);
            cyc();
        end
        reset = 1'b0;
        flush = 1'b0;

        // Stall counter saturation.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        in_words = '0;
        in_words[15:0] = 16'h00D1;
        in_regs = '0;
        cyc();
        in_valid = 1'b0;
        repeat (70000) cyc();
        chk("stall_sat", 128'(stall_count), 128'(16'hFFFF));
        repeat (3) cyc();
        chk("stall_hold", 128'(stall_count), 128'(16'hFFFF));
        chk("stall_valid", 128'(out_valid), 128'(1));
        chk("stall_payload", 128'(out_words[15:0]), 128'(16'h00D1));
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("stall_reset", 128'(stall_count), 128'(0));
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stage_buffer.md
STAGE_BUFFER -- requirements
Module: stage_buffer

Interface
REQ-001 Parameter WORD_W, default 16: width of each word field (matches lc3b_word).
REQ-002 Parameter NUM_WORDS, default 7: number of word fields carried per entry.
REQ-003 Parameter REG_W, default 3: width of each register-index field (matches lc3b_reg).
REQ-004 Parameter NUM_REGS, default 3: number of register-index fields carried per entry.
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 flush  input  1  discard every held entry (branch mispredict / redirect).
REQ-008 in_valid  input  1  upstream presents an entry.
REQ-009 in_ready  output  1  stage accepts an entry this cycle.
REQ-010 in_words  input  NUM_WORDS*WORD_W  packed word fields, field 0 in LSBs.
REQ-011 in_regs  input  NUM_REGS*REG_W  packed register fields, field 0 in LSBs.
REQ-012 out_valid  output  1  head entry present on out_words/out_regs.
REQ-013 out_ready  input  1  downstream accepts head entry.
REQ-014 out_words  output  NUM_WORDS*WORD_W  head entry word fields.
REQ-015 out_regs  output  NUM_REGS*REG_W  head entry register fields.
REQ-016 stall_count  output  16  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-017 Accept occurs when in_valid && in_ready; release occurs when out_valid && out_ready.
REQ-018 Entry accepted into an empty stage appears on outputs with out_valid=1 the next cycle (latency 1).
REQ-019 Strict FIFO order; no entry lost, duplicated or reordered.
REQ-020 Occupancy FSM states EMPTY, ONE, TWO: accept-only +1, release-only -1, accept+release or neither = unchanged.
REQ-021 In ONE with simultaneous accept and release, head is replaced by the new entry; state stays ONE.
REQ-022 In TWO, release moves skid entry to head next cycle; in_ready=0 so no accept occurs.
REQ-023 While out_valid=1 and out_ready=0, out_words/out_regs/out_valid hold unchanged.
REQ-024 flush: next state EMPTY, out_valid=0; any entry offered the same cycle is discarded; flush dominates in_valid and out_ready.
REQ-025 stall_count increments by 1 per stalled cycle, saturates at 0xFFFF (no wrap), unaffected by flush.
REQ-026 When out_valid=0, out payload holds its last value.

Reset
REQ-027 reset dominates flush and all handshakes; in_valid ignored during reset.
REQ-028 After reset: state EMPTY, out_valid=0, in_ready=1, out_words=0, out_regs=0, skid slot=0, stall_count=0.
REQ-029 Reset asserted mid-stall discards both entries; no entry is released after reset.

Configuration
REQ-030 Macro STAGE_BUFFER_SKID_EN defined: two-entry skid; in_ready = (state != TWO), a registered function of state only, no combinational path from out_ready.
REQ-031 Macro undefined: single entry, states EMPTY/ONE only; in_ready = !out_valid || out_ready (combinational); all other requirements unchanged.

Structure
REQ-032 The occupancy state enum (stage_occ_t: EMPTY, ONE, TWO) SHALL live in package lc3b_types.
REQ-033 Head and skid payload storage SHALL be built from the existing parametrised register sub-module (width = NUM_WORDS*WORD_W + NUM_REGS*REG_W).

Verification
REQ-034 Reset, then in_valid=1 with words field0=0x1234, out_ready=1 -> out_valid=1 and field0=0x1234 next cycle.
REQ-035 Stream 0x0001..0x0008 with out_ready toggling 1,0,1,0 -> outputs 0x0001..0x0008 in order, none missing or repeated.
REQ-036 (SKID_EN) Hold out_ready=0, offer 3 entries -> first two accepted, in_ready=0 on third; release yields first two in order.
REQ-037 Stage in TWO, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1; flushed entries never appear.
REQ-038 out_valid=1, out_ready=0 for 70000 cycles -> stall_count=0xFFFF, holds; reset -> 0.
REQ-039 Assert reset and flush together while stage is ONE -> all reset values of REQ-028 next cycle.
